// File: rtl/uart_dtm_frame_rx_if.sv
// rtl/uart_dtm_frame_rx_if.sv - byte stream in / decoded request out bundle for the DTM frame decoder
interface uart_dtm_frame_rx_if #(
  parameter int IRLENGTH = 5,
  parameter int MAXBYTES = 6
);
  localparam int CMDLENGTH = 8 - IRLENGTH;
  localparam int LENW      = $clog2(MAXBYTES + 1);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [CMDLENGTH-1:0]  cmd;
  logic [IRLENGTH-1:0]   addr;
  logic [8*MAXBYTES-1:0] data;
  logic [LENW-1:0]       len;
  logic                  valid;
  logic                  ready;
  logic                  err_cmd;
  logic                  err_timeout;

  // The decoder is the slave side: it sinks the byte stream and sources the request.
  modport slave (
    input  rx_data, rx_valid, ready,
    output rx_ready, cmd, addr, data, len, valid, err_cmd, err_timeout
  );

  modport master (
    output rx_data, rx_valid, ready,
    input  rx_ready, cmd, addr, data, len, valid, err_cmd, err_timeout
  );
endinterface

// File: rtl/uart_dtm_frame_rx.sv
// rtl/uart_dtm_frame_rx.sv - UART DTM receive frame decoder (header, command/address, payload, request out)
module uart_dtm_frame_rx #(
  parameter int                  IRLENGTH  = 5,
  parameter logic [7:0]          HEADER    = 8'h01,
  parameter logic [IRLENGTH-1:0] ADDR_DMI  = IRLENGTH'(5'b10001),
  parameter int                  DMI_BYTES = 6,
  parameter int                  REG_BYTES = 4,
  parameter int                  MAXBYTES  = 6,
  parameter int                  TIMEOUT   = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_dtm_frame_rx_if.slave  bus_if
);

  localparam int CMDLENGTH = 8 - IRLENGTH;
  localparam int LENW      = $clog2(MAXBYTES + 1);
  localparam int TW        = $clog2(TIMEOUT + 1);

  localparam logic [LENW-1:0] DMI_LEN = LENW'(DMI_BYTES);
  localparam logic [LENW-1:0] REG_LEN = LENW'(REG_BYTES);
  localparam logic [TW-1:0]   TMO_MAX = TW'(TIMEOUT);

  localparam logic [7:0] CMD_NOP   = 8'd0;
  localparam logic [7:0] CMD_READ  = 8'd1;
  localparam logic [7:0] CMD_WRITE = 8'd2;
  localparam logic [7:0] CMD_RW    = 8'd3;
  localparam logic [7:0] CMD_RESET = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_OUT
  } state_e;

  state_e                state_q, state_d;
  logic [CMDLENGTH-1:0]  cmd_q, cmd_d;
  logic [IRLENGTH-1:0]   addr_q, addr_d;
  logic [8*MAXBYTES-1:0] data_q, data_d;
  logic [LENW-1:0]       len_q, len_d;
  logic [LENW-1:0]       target_q, target_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_cmd_q, err_cmd_d;
  logic                  err_tmo_q, err_tmo_d;

  logic       rx_ready;
  logic       accept;
  logic [7:0] cmd_code;

  assign rx_ready = (state_q != ST_OUT);
  assign accept   = bus_if.rx_valid && rx_ready;
  // Command field zero-extended so the code table works for any IRLENGTH.
  assign cmd_code = {{IRLENGTH{1'b0}}, bus_if.rx_data[7:IRLENGTH]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      target_q  <= '0;
      tmo_q     <= '0;
      err_cmd_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      len_q     <= len_d;
      target_q  <= target_d;
      tmo_q     <= tmo_d;
      err_cmd_q <= err_cmd_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    len_d     = len_q;
    target_d  = target_q;
    tmo_d     = tmo_q;
    err_cmd_d = 1'b0;
    err_tmo_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (accept && (bus_if.rx_data == HEADER)) begin
          state_d = ST_CMD;
        end
      end

      ST_CMD, ST_PAYLOAD: begin
        // An expired counter wins over a byte arriving in the same cycle.
        if (tmo_q == TMO_MAX) begin
          err_tmo_d = 1'b1;
          tmo_d     = '0;
          state_d   = ST_IDLE;
        end else if (!accept) begin
          tmo_d = tmo_q + TW'(1);
        end else begin
          tmo_d = '0;
          if (state_q == ST_CMD) begin
            cmd_d    = bus_if.rx_data[7:IRLENGTH];
            addr_d   = bus_if.rx_data[IRLENGTH-1:0];
            data_d   = '0;
            len_d    = '0;
            target_d = (addr_d == ADDR_DMI) ? DMI_LEN : REG_LEN;
            case (cmd_code)
              CMD_WRITE, CMD_RW: begin
                state_d = (target_d == '0) ? ST_OUT : ST_PAYLOAD;
              end
              CMD_NOP, CMD_READ, CMD_RESET: begin
                state_d = ST_OUT;
              end
              default: begin
                err_cmd_d = 1'b1;
                state_d   = ST_IDLE;
              end
            endcase
          end else begin
            for (int k = 0; k < MAXBYTES; k++) begin
              if (len_q == LENW'(k)) begin
                data_d[8*k +: 8] = bus_if.rx_data;
              end
            end
            len_d = len_q + LENW'(1);
            if (len_d == target_q) begin
              state_d = ST_OUT;
            end
          end
        end
      end

      ST_OUT: begin
        tmo_d = '0;
        if (bus_if.ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_if.rx_ready    = rx_ready;
  assign bus_if.valid       = (state_q == ST_OUT);
  assign bus_if.cmd         = cmd_q;
  assign bus_if.addr        = addr_q;
  assign bus_if.data        = data_q;
  assign bus_if.len         = len_q;
  assign bus_if.err_cmd     = err_cmd_q;
  assign bus_if.err_timeout = err_tmo_q;

endmodule

// File: tb/tb_uart_dtm_frame_rx.sv
// tb/tb_uart_dtm_frame_rx.sv - directed self-checking bench for uart_dtm_frame_rx
module tb_uart_dtm_frame_rx;

  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_err_cmd = 0;
  int   n_err_tmo = 0;
  logic [7:0] fb [0:7];

  always #5 clk = ~clk;

  uart_dtm_frame_rx_if #(.IRLENGTH(5), .MAXBYTES(6)) bus ();

  uart_dtm_frame_rx #(
    .IRLENGTH (5),
    .HEADER   (8'h01),
    .ADDR_DMI (5'b10001),
    .DMI_BYTES(6),
    .REG_BYTES(4),
    .MAXBYTES (6),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus)
  );

  always @(negedge clk) begin
    if (bus.err_cmd === 1'b1)     n_err_cmd <= n_err_cmd + 1;
    if (bus.err_timeout === 1'b1) n_err_tmo <= n_err_tmo + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive fb[0..n-1] one byte per cycle; early counts valid seen before the last byte.
  task automatic send_frame(input int n, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      bus.rx_data  = fb[i];
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      if (i < n - 1 && bus.valid === 1'b1) early++;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic release_req();
    bus.ready = 1'b1;
    @(posedge clk); #1;
    bus.ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus.rx_ready, bus.valid} !== 2'b10) begin errors++;
      $display("FAIL reset_hs: got rx_ready/valid=%b expected 10", {bus.rx_ready, bus.valid}); end
    checks++; if ({bus.err_cmd, bus.err_timeout} !== 2'b00) begin errors++;
      $display("FAIL reset_err: got %b expected 00", {bus.err_cmd, bus.err_timeout}); end
    checks++; if ({bus.cmd, bus.addr, bus.len, bus.data} !== '0) begin errors++;
      $display("FAIL reset_fields: got cmd=%h addr=%h len=%0d data=%h expected all zero", bus.cmd, bus.addr, bus.len, bus.data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int early;
    fb[0] = 8'h01; fb[1] = 8'h30;
    send_frame(2, early);
    checks++; if (early !== 0 || bus.valid !== 1'b1) begin errors++;
      $display("FAIL read_valid: got early=%0d valid=%b expected 0 and 1", early, bus.valid); end
    checks++; if (bus.cmd !== 3'd1 || bus.addr !== 5'h10) begin errors++;
      $display("FAIL read_fields: got cmd=%0d addr=%h expected 1 10", bus.cmd, bus.addr); end
    checks++; if (bus.len !== 3'd0 || bus.data !== 48'h0) begin errors++;
      $display("FAIL read_payload: got len=%0d data=%h expected 0 0", bus.len, bus.data); end
    release_req();
    checks++; if (bus.valid !== 1'b0 || bus.rx_ready !== 1'b1) begin errors++;
      $display("FAIL read_release: got valid=%b rx_ready=%b expected 0 1", bus.valid, bus.rx_ready); end
  endtask

  task automatic test_dmi_write();
    int early;
    fb[0] = 8'h01; fb[1] = 8'h51; fb[2] = 8'h11; fb[3] = 8'h22;
    fb[4] = 8'h33; fb[5] = 8'h44; fb[6] = 8'h55; fb[7] = 8'h66;
    send_frame(8, early);
    checks++; if (early !== 0 || bus.valid !== 1'b1) begin errors++;
      $display("FAIL dmi_valid: got early=%0d valid=%b expected 0 1", early, bus.valid); end
    checks++; if (bus.cmd !== 3'd2 || bus.addr !== 5'h11 || bus.len !== 3'd6) begin errors++;
      $display("FAIL dmi_fields: got cmd=%0d addr=%h len=%0d expected 2 11 6", bus.cmd, bus.addr, bus.len); end
    checks++; if (bus.data !== 48'h665544332211) begin errors++;
      $display("FAIL dmi_data: got %h expected 665544332211", bus.data); end
    release_req();
  endtask

  task automatic test_garbage();
    int early;
    int c0, t0;
    c0 = n_err_cmd; t0 = n_err_tmo;
    fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h01; fb[3] = 8'h50;
    fb[4] = 8'hAA; fb[5] = 8'hBB; fb[6] = 8'hCC; fb[7] = 8'hDD;
    send_frame(8, early);
    checks++; if (early !== 0 || bus.valid !== 1'b1) begin errors++;
      $display("FAIL garbage_valid: got early=%0d valid=%b expected 0 1", early, bus.valid); end
    checks++; if (bus.cmd !== 3'd2 || bus.addr !== 5'h10 || bus.len !== 3'd4) begin errors++;
      $display("FAIL garbage_fields: got cmd=%0d addr=%h len=%0d expected 2 10 4", bus.cmd, bus.addr, bus.len); end
    checks++; if (bus.data !== 48'h0000DDCCBBAA) begin errors++;
      $display("FAIL garbage_data: got %h expected 0000ddccbbaa", bus.data); end
    release_req();
    checks++; if ((n_err_cmd - c0) !== 0 || (n_err_tmo - t0) !== 0) begin errors++;
      $display("FAIL garbage_noerr: got cmd_err=%0d tmo_err=%0d expected 0 0", n_err_cmd - c0, n_err_tmo - t0); end
  endtask

  task automatic test_illegal_cmd();
    int early;
    int c0;
    logic seen_valid;
    c0 = n_err_cmd;
    fb[0] = 8'h01; fb[1] = 8'hE1;
    send_frame(2, early);
    seen_valid = bus.valid;
    checks++; if (bus.err_cmd !== 1'b1) begin errors++;
      $display("FAIL illegal_pulse: got err_cmd=%b expected 1", bus.err_cmd); end
    @(posedge clk); #1;
    seen_valid = seen_valid | bus.valid;
    checks++; if (bus.err_cmd !== 1'b0) begin errors++;
      $display("FAIL illegal_width: got err_cmd=%b expected 0", bus.err_cmd); end
    checks++; if (seen_valid !== 1'b0 || (n_err_cmd - c0) !== 1) begin errors++;
      $display("FAIL illegal_count: got valid_seen=%b pulses=%0d expected 0 1", seen_valid, n_err_cmd - c0); end
    fb[0] = 8'h01; fb[1] = 8'h30;
    send_frame(2, early);
    checks++; if (bus.valid !== 1'b1 || bus.cmd !== 3'd1 || bus.addr !== 5'h10) begin errors++;
      $display("FAIL illegal_recover: got valid=%b cmd=%0d addr=%h expected 1 1 10", bus.valid, bus.cmd, bus.addr); end
    release_req();
  endtask

  task automatic test_timeout();
    int early;
    int t0, first;
    logic seen_valid;
    t0 = n_err_tmo; first = 0; seen_valid = 1'b0;
    fb[0] = 8'h01; fb[1] = 8'h50; fb[2] = 8'h12; fb[3] = 8'h34;
    send_frame(4, early);
    for (int i = 1; i <= TIMEOUT + 5; i++) begin
      @(posedge clk); #1;
      if (bus.err_timeout === 1'b1 && first == 0) first = i;
      if (bus.valid === 1'b1) seen_valid = 1'b1;
    end
    checks++; if (first !== TIMEOUT + 1) begin errors++;
      $display("FAIL timeout_cycle: got pulse at idle cycle %0d expected %0d", first, TIMEOUT + 1); end
    checks++; if ((n_err_tmo - t0) !== 1 || seen_valid !== 1'b0) begin errors++;
      $display("FAIL timeout_once: got pulses=%0d valid_seen=%b expected 1 0", n_err_tmo - t0, seen_valid); end
    fb[0] = 8'h01; fb[1] = 8'h10;
    send_frame(2, early);
    checks++; if (bus.valid !== 1'b1 || bus.cmd !== 3'd0 || bus.addr !== 5'h10 || bus.len !== 3'd0) begin errors++;
      $display("FAIL timeout_nop: got valid=%b cmd=%0d addr=%h len=%0d expected 1 0 10 0", bus.valid, bus.cmd, bus.addr, bus.len); end
    release_req();
  endtask

  task automatic test_backpressure();
    int early;
    int bad, t0;
    bad = 0; t0 = n_err_tmo;
    fb[0] = 8'h01; fb[1] = 8'h25;
    send_frame(2, early);
    bus.rx_data = 8'h01; bus.rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.valid !== 1'b1 || bus.rx_ready !== 1'b0 || bus.cmd !== 3'd1 || bus.addr !== 5'h05 ||
          bus.len !== 3'd0 || bus.data !== 48'h0) bad++;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    release_req();
    checks++; if (bus.valid !== 1'b0 || bus.rx_ready !== 1'b1 || (n_err_tmo - t0) !== 0) begin errors++;
      $display("FAIL bp_release: got valid=%b rx_ready=%b tmo=%0d expected 0 1 0", bus.valid, bus.rx_ready, n_err_tmo - t0); end
  endtask

  task automatic test_reset_midframe();
    int early;
    fb[0] = 8'h01; fb[1] = 8'h50; fb[2] = 8'h11; fb[3] = 8'h22; fb[4] = 8'h33;
    send_frame(5, early);
    checks++; if (bus.len !== 3'd3 || bus.data !== 48'h000000332211) begin errors++;
      $display("FAIL midrst_partial: got len=%0d data=%h expected 3 000000332211", bus.len, bus.data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.valid !== 1'b0 || bus.data !== 48'h0 || bus.len !== 3'd0 || bus.rx_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_async: got valid=%b data=%h len=%0d rx_ready=%b expected 0 0 0 1", bus.valid, bus.data, bus.len, bus.rx_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int early;
    fb[0] = 8'h01; fb[1] = 8'h30;
    send_frame(2, early);
    release_req();
    fb[0] = 8'h01; fb[1] = 8'h62; fb[2] = 8'hA1; fb[3] = 8'hB2; fb[4] = 8'hC3; fb[5] = 8'hD4;
    send_frame(6, early);
    checks++; if (early !== 0 || bus.valid !== 1'b1 || bus.cmd !== 3'd3 || bus.addr !== 5'h02 || bus.len !== 3'd4) begin errors++;
      $display("FAIL b2b_rw: got early=%0d valid=%b cmd=%0d addr=%h len=%0d expected 0 1 3 02 4", early, bus.valid, bus.cmd, bus.addr, bus.len); end
    checks++; if (bus.data !== 48'h0000D4C3B2A1) begin errors++;
      $display("FAIL b2b_data: got %h expected 0000d4c3b2a1", bus.data); end
    release_req();
    fb[0] = 8'h01; fb[1] = 8'h01;
    send_frame(2, early);
    checks++; if (bus.valid !== 1'b1 || bus.cmd !== 3'd0 || bus.addr !== 5'h01) begin errors++;
      $display("FAIL hdr_as_cmd: got valid=%b cmd=%0d addr=%h expected 1 0 01", bus.valid, bus.cmd, bus.addr); end
    release_req();
    fb[0] = 8'h01; fb[1] = 8'h81;
    send_frame(2, early);
    checks++; if (bus.valid !== 1'b1 || bus.cmd !== 3'd4 || bus.addr !== 5'h01 || bus.len !== 3'd0) begin errors++;
      $display("FAIL reset_cmd: got valid=%b cmd=%0d addr=%h len=%0d expected 1 4 01 0", bus.valid, bus.cmd, bus.addr, bus.len); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_read();
    test_dmi_write();
    test_garbage();
    test_illegal_cmd();
    test_timeout();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
